fft_power_seq: RTL and testbench

- Time-multiplexed replacement for a fully parallel 32-point FFT power stage.
- Captures one 32-bin complex FFT frame per valid/ready handshake.
- A single squarer-accumulator computes folded one-sided power for bins 0..16.
- Accumulates 2^AVG_LOG2 frames, then streams the averaged power bins one per handshake to the downstream spectrum logic.

---
 rtl/fft_power_seq_pkg.sv | 31 +++
 rtl/fft_power_seq_sq_acc.sv | 19 +
 rtl/fft_power_seq.sv | 135 +++++++++++++
 tb/tb_fft_power_seq.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_power_seq_pkg.sv
// fft_power_seq_pkg: shared constants, state encoding and MAC step decode
package fft_power_seq_pkg;

    localparam int NBINS  = 32;
    localparam int NOUT   = 17;
    localparam int NSTEPS = 64;

    typedef enum logic [1:0] {IDLE, COMP, EMIT} state_t;

    typedef struct packed {
        logic [4:0] bin;
        logic       imag;
        logic       mirror;
        logic       first;
    } step_t;

    // Bins 0 and 16 take two terms (r, i); bins 1..15 take four (r_k, i_k, r_32-k, i_32-k)
    function automatic step_t step_dec(input logic [5:0] s);
        step_t      d;
        logic [5:0] t;
        logic       edge_bin;
        t        = s - 6'd2;
        edge_bin = (s < 6'd2) || (s >= 6'd62);
        d.bin    = (s < 6'd2) ? 5'd0 : (s >= 6'd62) ? 5'd16 : 5'(t[5:2]) + 5'd1;
        d.imag   = s[0];
        d.mirror = !edge_bin && t[1];
        d.first  = edge_bin ? !s[0] : (t[1:0] == 2'd0);
        return d;
    endfunction

endpackage

// File: rtl/fft_power_seq_sq_acc.sv
// fft_sq_acc: signed square of one sample added to a selectable accumulator base
module fft_sq_acc #(
    parameter int W  = 4,
    parameter int AW = 2*W+1
) (
    input  logic signed [W-1:0]  x_i,
    input  logic        [AW-1:0] acc_i,
    input  logic                 first_i,
    output logic        [AW-1:0] sum_o
);

    logic signed [2*W-1:0] xe;
    logic signed [2*W-1:0] sq;

    assign xe    = {{W{x_i[W-1]}}, x_i};
    assign sq    = xe * xe;
    assign sum_o = (first_i ? '0 : acc_i) + AW'($unsigned(sq));

endmodule

// File: rtl/fft_power_seq.sv
// fft_power_seq: time-multiplexed averaged one-sided power of a 32-bin FFT frame
module fft_power_seq
    import fft_power_seq_pkg::*;
#(
    parameter int W        = 4,
    parameter int AVG_LOG2 = 2
) (
    input  logic               clk,
    input  logic               arst,
    input  logic               clr,
    input  logic               frm_valid,
    output logic               frm_ready,
    input  logic [NBINS*W-1:0] fft_r,
    input  logic [NBINS*W-1:0] fft_i,
    output logic               pwr_valid,
    input  logic               pwr_ready,
    output logic [2*W+2:0]     pwr_data,
    output logic [4:0]         pwr_idx,
    output logic               pwr_last,
    output logic               busy
);

    localparam int AW = 2*W+1+AVG_LOG2;
    localparam int FW = AVG_LOG2 > 0 ? AVG_LOG2 : 1;
    localparam int DW = 2*W+3;
    localparam logic [FW-1:0] FLAST = FW'((1 << AVG_LOG2) - 1);
    localparam logic [4:0]    ILAST = 5'(NOUT-1);

    state_t               state_q, state_d;
    logic [5:0]           step_q, step_d;
    logic [FW-1:0]        fcnt_q, fcnt_d;
    logic [4:0]           idx_q, idx_d;
    logic                 frm_ready_q, frm_ready_d;
    logic                 pwr_valid_q, pwr_valid_d;
    logic [DW-1:0]        pwr_data_q, pwr_data_d;
    logic                 pwr_last_q, pwr_last_d;
    logic                 busy_q, busy_d;
    logic [NBINS*W-1:0]   buf_r_q, buf_i_q;
    logic [AW-1:0]        acc_q [NOUT];
    step_t                dec;
    logic [4:0]           src;
    logic signed [W-1:0]  x;
    logic [AW-1:0]        sum;
    logic                 accept;
    logic                 emit_hs;

    assign dec     = step_dec(step_q);
    assign src     = dec.mirror ? 5'(NBINS - int'(dec.bin)) : dec.bin;
    assign x       = dec.imag ? buf_i_q[src*W +: W] : buf_r_q[src*W +: W];
    assign accept  = frm_valid && frm_ready_q && !clr;
    assign emit_hs = pwr_valid_q && pwr_ready;

    // The first term of a bin in the first frame of a set overwrites stale accumulator contents
    fft_sq_acc #(.W(W), .AW(AW)) u_mac (
        .x_i    (x),
        .acc_i  (acc_q[dec.bin]),
        .first_i(dec.first && fcnt_q == '0),
        .sum_o  (sum)
    );

    // Next-state and registered-output decode; clr overrides everything including a handshake
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        fcnt_d  = fcnt_q;
        idx_d   = idx_q;
        if (clr) begin
            state_d = IDLE;
            step_d  = '0;
            fcnt_d  = '0;
            idx_d   = '0;
        end else if (state_q == IDLE) begin
            state_d = accept ? COMP : IDLE;
            step_d  = '0;
        end else if (state_q == COMP) begin
            step_d = step_q + 6'd1;
            if (step_q == 6'(NSTEPS-1)) begin
                state_d = fcnt_q == FLAST ? EMIT : IDLE;
                fcnt_d  = fcnt_q == FLAST ? fcnt_q : fcnt_q + 1'b1;
                idx_d   = '0;
            end
        end else if (emit_hs) begin
            state_d = idx_q == ILAST ? IDLE : EMIT;
            fcnt_d  = idx_q == ILAST ? '0 : fcnt_q;
            idx_d   = idx_q == ILAST ? '0 : idx_q + 1'b1;
        end
        frm_ready_d = state_q == IDLE && state_d == IDLE;
        pwr_valid_d = state_q == EMIT && state_d == EMIT;
        pwr_data_d  = pwr_valid_d ? DW'(acc_q[idx_d] >> AVG_LOG2) : '0;
        pwr_last_d  = pwr_valid_d && idx_d == ILAST;
        busy_d      = state_d != IDLE;
    end

    // Control state and registered outputs
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q     <= IDLE;
            step_q      <= '0;
            fcnt_q      <= '0;
            idx_q       <= '0;
            frm_ready_q <= 1'b0;
            pwr_valid_q <= 1'b0;
            pwr_data_q  <= '0;
            pwr_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            fcnt_q      <= fcnt_d;
            idx_q       <= idx_d;
            frm_ready_q <= frm_ready_d;
            pwr_valid_q <= pwr_valid_d;
            pwr_data_q  <= pwr_data_d;
            pwr_last_q  <= pwr_last_d;
            busy_q      <= busy_d;
        end
    end

    // Frame capture and per-bin accumulation
    always_ff @(posedge clk) begin
        if (accept) begin
            buf_r_q <= fft_r;
            buf_i_q <= fft_i;
        end
        if (state_q == COMP && !clr) acc_q[dec.bin] <= sum;
    end

    assign frm_ready = frm_ready_q;
    assign pwr_valid = pwr_valid_q;
    assign pwr_data  = pwr_data_q;
    assign pwr_idx   = idx_q;
    assign pwr_last  = pwr_last_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_fft_power_seq.sv
// tb_fft_power_seq: directed table-driven and corner-case checks of fft_power_seq
module tb_fft_power_seq;

    localparam int NOUT = 17;

    typedef struct {
        logic [3:0] r;
        logic [3:0] i;
        int         e0;
        int         em;
        int         e16;
    } vec_t;

    logic         clk = 1'b0;
    logic         arst;
    logic         clr       [3];
    logic         frm_valid [3];
    logic         pwr_ready [3];
    logic [127:0] fft_r     [3];
    logic [127:0] fft_i     [3];
    logic         frm_ready [3];
    logic         pwr_valid [3];
    logic         pwr_last  [3];
    logic         busy      [3];
    logic [10:0]  pwr_data  [3];
    logic [4:0]   pwr_idx   [3];
    logic [10:0]  expv      [NOUT];
    vec_t         tv        [6];
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    fft_power_seq #(.W(4), .AVG_LOG2(0)) u0 (
        .clk(clk), .arst(arst), .clr(clr[0]), .frm_valid(frm_valid[0]), .frm_ready(frm_ready[0]),
        .fft_r(fft_r[0]), .fft_i(fft_i[0]), .pwr_valid(pwr_valid[0]), .pwr_ready(pwr_ready[0]),
        .pwr_data(pwr_data[0]), .pwr_idx(pwr_idx[0]), .pwr_last(pwr_last[0]), .busy(busy[0])
    );
    fft_power_seq #(.W(4), .AVG_LOG2(1)) u1 (
        .clk(clk), .arst(arst), .clr(clr[1]), .frm_valid(frm_valid[1]), .frm_ready(frm_ready[1]),
        .fft_r(fft_r[1]), .fft_i(fft_i[1]), .pwr_valid(pwr_valid[1]), .pwr_ready(pwr_ready[1]),
        .pwr_data(pwr_data[1]), .pwr_idx(pwr_idx[1]), .pwr_last(pwr_last[1]), .busy(busy[1])
    );
    fft_power_seq #(.W(4), .AVG_LOG2(2)) u2 (
        .clk(clk), .arst(arst), .clr(clr[2]), .frm_valid(frm_valid[2]), .frm_ready(frm_ready[2]),
        .fft_r(fft_r[2]), .fft_i(fft_i[2]), .pwr_valid(pwr_valid[2]), .pwr_ready(pwr_ready[2]),
        .pwr_data(pwr_data[2]), .pwr_idx(pwr_idx[2]), .pwr_last(pwr_last[2]), .busy(busy[2])
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int sq(input logic signed [3:0] v);
        return int'(v) * int'(v);
    endfunction

    function automatic int pw(input logic [127:0] r, input logic [127:0] i, input int k);
        int s;
        s = sq(r[k*4 +: 4]) + sq(i[k*4 +: 4]);
        if (k != 0 && k != 16) s += sq(r[(32-k)*4 +: 4]) + sq(i[(32-k)*4 +: 4]);
        return s;
    endfunction

    task automatic fill_exp(input int e0, input int em, input int e16);
        for (int b = 0; b < NOUT; b++) expv[b] = 11'(b == 0 ? e0 : b == 16 ? e16 : em);
    endtask

    task automatic send(input int n, input logic [127:0] r, input logic [127:0] i);
        int k;
        k = 0;
        fft_r[n] = r;
        fft_i[n] = i;
        frm_valid[n] = 1'b1;
        while (!frm_ready[n] && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk($sformatf("accept u%0d", n), 64'(k < 300), 1);
        @(negedge clk);
        frm_valid[n] = 1'b0;
    endtask

    task automatic lat(input int n, input int exp);
        int c;
        c = 0;
        while (!pwr_valid[n] && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk($sformatf("latency u%0d", n), c, exp);
    endtask

    task automatic recv(input int n, input int stall);
        int k;
        for (int b = 0; b < NOUT; b++) begin
            k = 0;
            while (!pwr_valid[n] && k < 200) begin
                @(negedge clk);
                k++;
            end
            chk($sformatf("u%0d idx b%0d", n, b), pwr_idx[n], b);
            chk($sformatf("u%0d data b%0d", n, b), pwr_data[n], expv[b]);
            chk($sformatf("u%0d last b%0d", n, b), pwr_last[n], 64'(b == 16));
            if (b == stall) begin
                pwr_ready[n] = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    chk("stall valid", pwr_valid[n], 1);
                    chk("stall idx", pwr_idx[n], b);
                    chk("stall data", pwr_data[n], expv[b]);
                end
                pwr_ready[n] = 1'b1;
            end
            @(negedge clk);
        end
        chk($sformatf("u%0d valid after last", n), pwr_valid[n], 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [127:0] br, bi;
        int bad;
        bit seen;
        tv[0] = '{4'h1, 4'h0, 1, 2, 1};
        tv[1] = '{4'h8, 4'h8, 128, 256, 128};
        tv[2] = '{4'h3, 4'hE, 13, 26, 13};
        tv[3] = '{4'h0, 4'h0, 0, 0, 0};
        tv[4] = '{4'hF, 4'h7, 50, 100, 50};
        tv[5] = '{4'h7, 4'h7, 98, 196, 98};
        arst = 1'b1;
        for (int n = 0; n < 3; n++) begin
            clr[n] = 1'b0;
            frm_valid[n] = 1'b0;
            pwr_ready[n] = 1'b1;
            fft_r[n] = '0;
            fft_i[n] = '0;
        end
        repeat (3) @(negedge clk);
        chk("rst frm_ready", frm_ready[0], 0);
        chk("rst pwr_valid", pwr_valid[0], 0);
        chk("rst pwr_data", pwr_data[0], 0);
        chk("rst pwr_idx", pwr_idx[0], 0);
        chk("rst pwr_last", pwr_last[0], 0);
        chk("rst busy", busy[0], 0);
        arst = 1'b0;
        #1;
        chk("frm_ready before edge", frm_ready[0], 0);
        @(negedge clk);
        for (int n = 0; n < 3; n++) chk($sformatf("frm_ready rise u%0d", n), frm_ready[n], 1);

        // uniform frames, no averaging
        for (int t = 0; t < 6; t++) begin
            fill_exp(tv[t].e0, tv[t].em, tv[t].e16);
            send(0, {32{tv[t].r}}, {32{tv[t].i}});
            lat(0, 65);
            recv(0, -1);
        end

        // non-uniform frame with backpressure at idx 3
        for (int k = 0; k < 32; k++) begin
            br[k*4 +: 4] = 4'(k);
            bi[k*4 +: 4] = 4'(3*k);
        end
        for (int b = 0; b < NOUT; b++) expv[b] = 11'(pw(br, bi, b));
        send(0, br, bi);
        recv(0, 3);

        // four-frame average on u2
        seen = 1'b0;
        for (int f = 0; f < 3; f++) begin
            send(2, 128'h10, 128'h0);
            repeat (66) begin
                @(negedge clk);
                if (pwr_valid[2]) seen = 1'b1;
            end
        end
        chk("early pwr_valid u2", 64'(seen), 0);
        fill_exp(0, 0, 0);
        expv[1] = 11'd1;
        send(2, 128'h10 | (128'h1 << 124), 128'h10);
        lat(2, 65);
        recv(2, -1);

        // clr at step 30 on u1, then two fresh frames
        send(1, {32{4'h7}}, {32{4'h7}});
        repeat (30) @(negedge clk);
        clr[1] = 1'b1;
        @(negedge clk);
        clr[1] = 1'b0;
        chk("clr busy", busy[1], 0);
        chk("clr pwr_valid", pwr_valid[1], 0);
        send(1, {32{4'h1}}, {32{4'h0}});
        send(1, {32{4'h2}}, {32{4'h1}});
        fill_exp(3, 6, 3);
        lat(1, 65);
        recv(1, -1);

        // arst during EMIT at idx 8
        send(0, {32{4'h1}}, {32{4'h0}});
        bad = 0;
        while (!(pwr_valid[0] && pwr_idx[0] == 5'd8) && bad < 200) begin
            @(negedge clk);
            bad++;
        end
        chk("reach idx8", pwr_idx[0], 8);
        pwr_ready[0] = 1'b0;
        #2 arst = 1'b1;
        #1;
        chk("arst pwr_valid", pwr_valid[0], 0);
        chk("arst busy", busy[0], 0);
        chk("arst pwr_idx", pwr_idx[0], 0);
        @(negedge clk);
        arst = 1'b0;
        pwr_ready[0] = 1'b1;
        chk("arst frm_ready low", frm_ready[0], 0);
        @(negedge clk);
        chk("arst frm_ready rise", frm_ready[0], 1);
        chk("arst no valid", pwr_valid[0], 0);

        // frm_valid held through COMP on u1 is not re-accepted until IDLE
        fft_r[1] = {32{4'h1}};
        fft_i[1] = '0;
        frm_valid[1] = 1'b1;
        @(negedge clk);
        bad = 0;
        for (int c = 1; c <= 64; c++) begin
            @(negedge clk);
            if (frm_ready[1] || (c < 64 && !busy[1])) bad++;
        end
        chk("held valid ready during comp", bad, 0);
        @(negedge clk);
        chk("held valid ready back", frm_ready[1], 1);
        chk("held valid busy idle", busy[1], 0);
        frm_valid[1] = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
